// File: rtl/mul_pkg.sv
// Shared types and sizing helpers for the digit-serial multiplier.
package mul_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    function automatic int digits_of(input int width);
        return width / 2;
    endfunction

    function automatic int cnt_width(input int digits);
        return (digits > 1) ? $clog2(digits) : 1;
    endfunction

endpackage

// File: rtl/mul_digit_serial_cell.sv
// Exact 2x2 unsigned multiplier cell, purely combinational.
module mul2x2_cell (
    input  logic [1:0] a,
    input  logic [1:0] b,
    output logic [3:0] p
);

    assign p = ({2'b00, a} & {4{b[0]}})
             + ({1'b0, a, 1'b0} & {4{b[1]}});

endmodule

// File: rtl/mul_digit_serial.sv
// Unsigned WIDTHxWIDTH multiplier consuming B one 2-bit digit per cycle,
// with valid/ready handshakes on both sides.
module mul_digit_serial
    import mul_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter bit EARLY_EXIT = 1'b1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] p,
    output logic               busy
);

    localparam int DIGITS = digits_of(WIDTH);
    localparam int CW     = cnt_width(DIGITS);
    localparam int PW     = 2 * WIDTH;
    localparam int RW     = WIDTH + 2;

    if ((WIDTH % 2) != 0 || WIDTH < 4 || WIDTH > 32) begin : g_bad_width
        $error("mul_digit_serial: WIDTH must be even and in 4..32");
    end

    state_t          state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [PW-1:0]   acc_q, acc_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            out_valid_q, out_valid_d;
    logic [PW-1:0]   p_q, p_d;

    logic [3:0]      cell_p [DIGITS];
    logic [RW-1:0]   row;
    logic [PW-1:0]   row_sh;
    logic            last;

    for (genvar k = 0; k < DIGITS; k++) begin : g_row
        mul2x2_cell u_cell (
            .a (a_q[2*k+1:2*k]),
            .b (b_sh_q[1:0]),
            .p (cell_p[k])
        );
    end

    always_comb begin
        row = '0;
        for (int k = 0; k < DIGITS; k++) begin
            row = row + (RW'(cell_p[k]) << (2 * k));
        end
    end

    // Row weight is 4^cnt: the digit index scales the row by 2*cnt bits.
    assign row_sh = PW'(row) << {cnt_q, 1'b0};

    assign last = (cnt_q == CW'(DIGITS - 1))
               || (EARLY_EXIT && ((b_sh_q >> 2) == '0));

    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        b_sh_d      = b_sh_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        out_valid_d = out_valid_q;
        p_d         = p_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    b_sh_d  = b;
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                acc_d  = acc_q + row_sh;
                b_sh_d = b_sh_q >> 2;
                cnt_d  = cnt_q + CW'(1);
                if (last) begin
                    state_d     = DONE;
                    out_valid_d = 1'b1;
                    p_d         = acc_d;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d     = IDLE;
                    out_valid_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_sh_q      <= '0;
            acc_q       <= '0;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            p_q         <= '0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_sh_q      <= b_sh_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
            p_q         <= p_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign out_valid = out_valid_q;
    assign p         = p_q;

endmodule

// File: tb/tb_mul_digit_serial.sv
// Bench for mul_digit_serial: WIDTH=8 with and without early exit,
// WIDTH=16 random sweep, and the standalone 2x2 cell.
module tb_mul_digit_serial;

    logic        clk;
    logic        rst_n;

    logic        iv [3];
    logic        orr [3];
    logic        ir [3];
    logic        ov [3];
    logic        bz [3];
    logic [7:0]  a8 [2];
    logic [7:0]  b8 [2];
    logic [15:0] p8e, p8n;
    logic [15:0] a16, b16;
    logic [31:0] p16;

    logic [1:0]  ca, cb;
    logic [3:0]  cp;

    int total;
    int passed;

    mul_digit_serial #(.WIDTH(8), .EARLY_EXIT(1'b1)) u_8e (
        .clk(clk), .rst_n(rst_n),
        .in_valid(iv[0]), .in_ready(ir[0]),
        .a(a8[0]), .b(b8[0]),
        .out_valid(ov[0]), .out_ready(orr[0]),
        .p(p8e), .busy(bz[0])
    );

    mul_digit_serial #(.WIDTH(8), .EARLY_EXIT(1'b0)) u_8n (
        .clk(clk), .rst_n(rst_n),
        .in_valid(iv[1]), .in_ready(ir[1]),
        .a(a8[1]), .b(b8[1]),
        .out_valid(ov[1]), .out_ready(orr[1]),
        .p(p8n), .busy(bz[1])
    );

    mul_digit_serial #(.WIDTH(16), .EARLY_EXIT(1'b1)) u_16 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(iv[2]), .in_ready(ir[2]),
        .a(a16), .b(b16),
        .out_valid(ov[2]), .out_ready(orr[2]),
        .p(p16), .busy(bz[2])
    );

    mul2x2_cell u_cell (.a(ca), .b(cb), .p(cp));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] get_p(input int d);
        if (d == 0) return {16'h0, p8e};
        if (d == 1) return {16'h0, p8n};
        return p16;
    endfunction

    task automatic set_in(input int d, input logic v,
                          input logic [15:0] a, input logic [15:0] b);
        iv[d] = v;
        if (d < 2) begin
            a8[d] = a[7:0];
            b8[d] = b[7:0];
        end else begin
            a16 = a;
            b16 = b;
        end
    endtask

    // Reference latency: digits processed until the highest nonzero digit.
    function automatic int exp_lat(input int digits, input bit ee,
                                   input logic [15:0] b);
        int r;
        if (!ee) return digits;
        r = 1;
        for (int i = 0; i < digits; i++)
            if (((b >> (2 * i)) % 4) != 0) r = i + 1;
        return r;
    endfunction

    // One full transaction; returns observations, judges nothing.
    task automatic xact(input int d, input logic [15:0] a, input logic [15:0] b,
                        input int stall, output logic [31:0] p, output int lat,
                        output bit unstable, output bit irbad, output bit ir_after);
        int n;
        logic [31:0] p0;
        unstable = 1'b0;
        irbad    = 1'b0;
        lat      = -1;
        n        = 0;
        while (ir[d] !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        set_in(d, 1'b1, a, b);
        tick();
        set_in(d, 1'b0, 16'($urandom), 16'($urandom));
        for (int c = 1; c <= 64; c++) begin
            tick();
            if (ir[d] !== 1'b0 || bz[d] !== 1'b1) irbad = 1'b1;
            if (ov[d] === 1'b1) begin
                lat = c;
                break;
            end
        end
        p  = get_p(d);
        p0 = p;
        for (int s = 0; s < stall; s++) begin
            set_in(d, 1'b1, 16'($urandom), 16'($urandom));
            tick();
            if (ov[d] !== 1'b1 || get_p(d) !== p0 || ir[d] !== 1'b0)
                unstable = 1'b1;
        end
        set_in(d, 1'b0, 16'h0, 16'h0);
        orr[d] = 1'b1;
        tick();
        orr[d]   = 1'b0;
        ir_after = ir[d];
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        for (int d = 0; d < 3; d++) begin
            set_in(d, 1'b0, 16'h0, 16'h0);
            orr[d] = 1'b0;
        end
        ca = 2'd0;
        cb = 2'd0;
        repeat (3) tick();
        for (int d = 0; d < 3; d++) begin
            total++;
            if (ir[d] !== 1'b1) $display("FAIL reset_in_ready d%0d: got %b want 1", d, ir[d]);
            else passed++;
            total++;
            if (ov[d] !== 1'b0) $display("FAIL reset_out_valid d%0d: got %b want 0", d, ov[d]);
            else passed++;
            total++;
            if (bz[d] !== 1'b0) $display("FAIL reset_busy d%0d: got %b want 0", d, bz[d]);
            else passed++;
            total++;
            if (get_p(d) !== 32'h0) $display("FAIL reset_p d%0d: got %0h want 0", d, get_p(d));
            else passed++;
        end
        #4 rst_n = 1'b1;
        tick();
    endtask

    task automatic test_cell();
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 4; j++) begin
                ca = 2'(i);
                cb = 2'(j);
                #1;
                total++;
                if (cp !== 4'(i * j))
                    $display("FAIL cell %0dx%0d: got %0d want %0d", i, j, cp, i * j);
                else passed++;
            end
        end
    endtask

    task automatic test_full_scale();
        logic [31:0] p;
        int lat;
        bit us, ib, ia;
        xact(0, 16'd255, 16'd255, 0, p, lat, us, ib, ia);
        total++;
        if (p !== 32'd65025) $display("FAIL full_scale_p: got %0d want 65025", p);
        else passed++;
        total++;
        if (lat != 4) $display("FAIL full_scale_lat: got %0d want 4", lat);
        else passed++;
    endtask

    task automatic test_early_exit();
        logic [31:0] p;
        int lat;
        bit us, ib, ia;
        for (int d = 0; d < 2; d++) begin
            xact(d, 16'd3, 16'd3, 0, p, lat, us, ib, ia);
            total++;
            if (p !== 32'd9) $display("FAIL early_exit_p d%0d: got %0d want 9", d, p);
            else passed++;
            total++;
            if (lat != ((d == 0) ? 1 : 4))
                $display("FAIL early_exit_lat d%0d: got %0d want %0d", d, lat, (d == 0) ? 1 : 4);
            else passed++;
        end
    endtask

    task automatic test_zero_mult();
        logic [31:0] p;
        int lat;
        bit us, ib, ia;
        xact(0, 16'd200, 16'd0, 3, p, lat, us, ib, ia);
        total++;
        if (p !== 32'd0) $display("FAIL zero_p: got %0d want 0", p);
        else passed++;
        total++;
        if (lat != 1) $display("FAIL zero_lat: got %0d want 1", lat);
        else passed++;
        total++;
        if (ib || us) $display("FAIL zero_in_ready_low: got in_ready/busy glitch %b%b want 00", ib, us);
        else passed++;
        total++;
        if (ia !== 1'b1) $display("FAIL zero_ready_after: got %b want 1", ia);
        else passed++;
    endtask

    task automatic test_back_pressure();
        logic [31:0] p;
        int lat;
        bit us, ib, ia;
        xact(0, 16'd12, 16'd10, 5, p, lat, us, ib, ia);
        total++;
        if (p !== 32'd120) $display("FAIL bp_p: got %0d want 120", p);
        else passed++;
        total++;
        if (us) $display("FAIL bp_stable: got unstable=1 want 0");
        else passed++;
        total++;
        if (ia !== 1'b1) $display("FAIL bp_ready_after: got %b want 1", ia);
        else passed++;
        total++;
        if (lat != exp_lat(4, 1'b1, 16'd10))
            $display("FAIL bp_lat: got %0d want %0d", lat, exp_lat(4, 1'b1, 16'd10));
        else passed++;
    endtask

    task automatic test_reset_mid();
        logic [31:0] p;
        int lat;
        bit us, ib, ia;
        set_in(0, 1'b1, 16'd200, 16'd200);
        tick();
        set_in(0, 1'b0, 16'h0, 16'h0);
        tick();
        total++;
        if (bz[0] !== 1'b1) $display("FAIL mid_busy_before: got %b want 1", bz[0]);
        else passed++;
        rst_n = 1'b0;
        #1;
        total++;
        if (ov[0] !== 1'b0) $display("FAIL mid_out_valid: got %b want 0", ov[0]);
        else passed++;
        total++;
        if (ir[0] !== 1'b1) $display("FAIL mid_in_ready: got %b want 1", ir[0]);
        else passed++;
        total++;
        if (p8e !== 16'h0) $display("FAIL mid_p: got %0d want 0", p8e);
        else passed++;
        #2 rst_n = 1'b1;
        tick();
        repeat (6) begin
            tick();
            total++;
            if (ov[0] !== 1'b0) $display("FAIL mid_no_emit: got %b want 0", ov[0]);
            else passed++;
        end
        xact(0, 16'd7, 16'd9, 0, p, lat, us, ib, ia);
        total++;
        if (p !== 32'd63) $display("FAIL mid_after_p: got %0d want 63", p);
        else passed++;
    endtask

    task automatic test_back_to_back();
        logic [31:0] p;
        int lat;
        bit us, ib, ia;
        logic [15:0] a, b;
        for (int i = 0; i < 8; i++) begin
            a = 16'($urandom_range(0, 255));
            b = 16'($urandom_range(0, 255));
            xact(1, a, b, 0, p, lat, us, ib, ia);
            total++;
            if (p !== 32'(a) * 32'(b) || lat != 4 || ia !== 1'b1)
                $display("FAIL b2b %0dx%0d: got p=%0d lat=%0d rdy=%b want p=%0d lat=4 rdy=1",
                         a, b, p, lat, ia, 32'(a) * 32'(b));
            else passed++;
        end
    endtask

    task automatic test_random16();
        logic [31:0] p;
        int lat, el, stall;
        bit us, ib, ia;
        logic [15:0] a, b;
        logic [15:0] corner [5];
        corner[0] = 16'h0000;
        corner[1] = 16'h0001;
        corner[2] = 16'hFFFF;
        corner[3] = 16'hAAAA;
        corner[4] = 16'h5555;
        for (int i = 0; i < 25 + 2000; i++) begin
            if (i < 25) begin
                a = corner[i / 5];
                b = corner[i % 5];
            end else begin
                a = 16'($urandom);
                b = 16'($urandom);
                if (($urandom % 4) == 0) b = b & 16'h00FF;
            end
            stall = (($urandom % 4) == 0) ? int'($urandom_range(1, 3)) : 0;
            xact(2, a, b, stall, p, lat, us, ib, ia);
            el = exp_lat(8, 1'b1, b);
            total++;
            if (p !== 32'(a) * 32'(b))
                $display("FAIL rand16_p %0h*%0h: got %0h want %0h", a, b, p, 32'(a) * 32'(b));
            else passed++;
            total++;
            if (lat != el || us || ib || ia !== 1'b1)
                $display("FAIL rand16_timing %0h*%0h: got lat=%0d us=%b ib=%b rdy=%b want lat=%0d 0 0 1",
                         a, b, lat, us, ib, ia, el);
            else passed++;
        end
    endtask

    initial begin
        total  = 0;
        passed = 0;
        test_reset();
        test_cell();
        test_full_scale();
        test_early_exit();
        test_zero_mult();
        test_back_pressure();
        test_reset_mid();
        test_back_to_back();
        test_random16();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
